fifo_drain_arbiter: RTL

FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/rr_grant_sel.sv | 24 ++
 rtl/fifo_drain_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - state encoding and round-robin pick shared by fifo_drain_arbiter
package fifo_arb_pkg;

   localparam int MAX_SRC = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } arb_state_t;

   // Nearest set bit of req at or after ptr (wrapping modulo n); ptr when req is empty.
   function automatic int rr_pick(input logic [MAX_SRC-1:0] req, input int ptr, input int n);
      int idx;
      rr_pick = ptr;
      for (int i = MAX_SRC - 1; i >= 0; i--) begin
         if (i < n) begin
            idx = (ptr + i) % n;
            if (req[idx[2:0]]) rr_pick = idx;
         end
      end
   endfunction

endpackage

// File: rtl/rr_grant_sel.sv
// rtl/rr_grant_sel.sv - combinational round-robin priority encoder over the source requests
module rr_grant_sel
   import fifo_arb_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int PW    = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [PW-1:0]    gnt_idx,
   output logic             gnt_any
);

   logic [MAX_SRC-1:0] req_ext;

   always_comb begin
      req_ext            = '0;
      req_ext[N_SRC-1:0] = req;
   end

   assign gnt_idx = PW'(rr_pick(req_ext, int'(ptr), N_SRC));
   assign gnt_any = |req;

endmodule

// File: rtl/fifo_drain_arbiter.sv
// rtl/fifo_drain_arbiter.sv - round-robin burst drain of N_SRC prefetch FIFOs into one stream
// Optional FIFO_ARB_LAST_EN adds out_last, flagging the BURST_LEN-th word of a burst.
module fifo_drain_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int DW        = 8,
   parameter int BURST_LEN = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [N_SRC-1:0]         src_vld,
   input  logic [N_SRC*DW-1:0]      src_data,
   output logic [N_SRC-1:0]         src_rd_en,
   output logic [DW-1:0]            out_data,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [$clog2(N_SRC)-1:0] out_src,
   output logic                     busy
`ifdef FIFO_ARB_LAST_EN
   ,
   output logic                     out_last
`endif
);

   localparam int PW = $clog2(N_SRC);
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);
   localparam logic [PW-1:0] LAST_SRC = PW'(N_SRC - 1);

   arb_state_t    state;
   logic [PW-1:0] g;
   logic [PW-1:0] rr_ptr;
   logic [CW-1:0] cnt;
   logic [PW-1:0] sel_idx;
   logic          sel_any;
   logic          in_burst;
   logic          g_vld;
   logic          xfer;

   rr_grant_sel #(
      .N_SRC (N_SRC),
      .PW    (PW)
   ) u_sel (
      .req     (src_vld),
      .ptr     (rr_ptr),
      .gnt_idx (sel_idx),
      .gnt_any (sel_any)
   );

   // Data path is combinational from the registered grant so a word moves every cycle.
   assign in_burst = (state == BURST);
   assign g_vld    = src_vld[g];
   assign xfer     = in_burst & g_vld & out_rdy;
   assign out_vld  = in_burst & g_vld;
   assign out_data = src_data[g*DW +: DW];
   assign out_src  = g;

   always_comb begin
      src_rd_en    = '0;
      src_rd_en[g] = xfer;
   end

`ifdef FIFO_ARB_LAST_EN
   assign out_last = out_vld & (cnt == LAST_CNT);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         g      <= '0;
         rr_ptr <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en && sel_any) begin
                  g     <= sel_idx;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= BURST;
               end
            end
            BURST: begin
               if (xfer) cnt <= cnt + 1'b1;
               // An empty source ends the burst even when nothing was transferred.
               if ((xfer && cnt == LAST_CNT) || !g_vld) state <= DONE;
            end
            DONE: begin
               rr_ptr <= (g == LAST_SRC) ? '0 : g + 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
